// File: rtl/sr_flag_ctrl.sv
// ---------------------------------------------------------------------------
// sr_flag_ctrl
//
// Serialises set/reset/hold commands from NREQ requesters onto a shared bank
// of NFLAG SR status flags. Each command takes three cycles:
//   IDLE  : pick a winner and capture its op/idx
//   APPLY : update the addressed flag, or trap an illegal/out-of-range op
//   ACK   : advance the round-robin pointer; the registered grant pulses in
//           the following cycle
//
// Optional build macro SR_FLAG_CTRL_FIXED_PRIO_EN:
//   defined   -> fixed priority, lowest-index requester wins (no pointer)
//   undefined -> round-robin starting from the requester after the last winner
// ---------------------------------------------------------------------------
module sr_flag_ctrl #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [IDXW*NREQ-1:0]   req_idx,
    input  logic                   err_clr,
    output logic [NREQ-1:0]        gnt,
    output logic [NFLAG-1:0]       q,
    output logic                   busy,
    output logic                   err,
    output logic [IDXW-1:0]        err_src
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Index limit widened by one bit so idx values >= NFLAG are detectable
    // even when NFLAG is an exact power of two.
    localparam logic [IDXW:0] NFLAG_LIM = (IDXW + 1)'(NFLAG);

`ifndef SR_FLAG_CTRL_FIXED_PRIO_EN
    localparam logic [PTRW-1:0] LAST_ID = PTRW'(NREQ - 1);
`endif

    // {S,R} command encodings
    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_RESET = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_ILLEG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTRW-1:0]   win_q,   win_d;
    logic [1:0]        op_q,    op_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [NFLAG-1:0]  q_q,     q_d;
    logic              err_q,   err_d;
    logic [IDXW-1:0]   err_src_q, err_src_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic              busy_q,  busy_d;

`ifndef SR_FLAG_CTRL_FIXED_PRIO_EN
    logic [PTRW-1:0]   ptr_q,   ptr_d;
`endif

    // Arbitration result for the current cycle
    logic              found;
    logic [PTRW-1:0]   win_sel;
    logic [1:0]        op_sel;
    logic [IDXW-1:0]   idx_sel;
    logic              trap;

    // Winner selection: round-robin scans from ptr upwards, then wraps to 0.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; a missed default would infer a latch.
    always_comb begin
        found   = 1'b0;
        win_sel = '0;
        op_sel  = OP_HOLD;
        idx_sel = '0;
`ifndef SR_FLAG_CTRL_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k] && (PTRW'(k) >= ptr_q)) begin
                found   = 1'b1;
                win_sel = PTRW'(k);
                op_sel  = req_op[2*k +: 2];
                idx_sel = req_idx[IDXW*k +: IDXW];
            end
        end
`endif
        // Wrap-around pass (round-robin) or the whole scan (fixed priority)
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                found   = 1'b1;
                win_sel = PTRW'(k);
                op_sel  = req_op[2*k +: 2];
                idx_sel = req_idx[IDXW*k +: IDXW];
            end
        end
    end

    // Next-state logic and command capture
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_APPLY;
                    win_d   = win_sel;
                    op_d    = op_sel;
                    idx_d   = idx_sel;
                end
            end
            ST_APPLY: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifndef SR_FLAG_CTRL_FIXED_PRIO_EN
    // Pointer moves past the winner as the ACK cycle completes
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_ACK) begin
            ptr_d = (win_q == LAST_ID) ? '0 : win_q + PTRW'(1);
        end
    end
`endif

    // Flag bank update and sticky error; a trap in APPLY overrides err_clr
    always_comb begin
        q_d       = q_q;
        err_d     = err_q;
        err_src_d = err_src_q;
        trap      = (op_q == OP_ILLEG) || ({1'b0, idx_q} >= NFLAG_LIM);
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (state_q == ST_APPLY) begin
            if (trap) begin
                err_d     = 1'b1;
                err_src_d = idx_q;
            end else begin
                for (int f = 0; f < NFLAG; f++) begin
                    if (idx_q == IDXW'(f)) begin
                        if (op_q == OP_SET) begin
                            q_d[f] = 1'b1;
                        end else if (op_q == OP_RESET) begin
                            q_d[f] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Output decodes: grant follows the ACK cycle by one clock, busy tracks
    // the state register exactly
    always_comb begin
        gnt_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt_d[k] = (state_q == ST_ACK) && (win_q == PTRW'(k));
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Control state registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            op_q    <= OP_HOLD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

`ifndef SR_FLAG_CTRL_FIXED_PRIO_EN
    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Flag bank and error registers
    // NOTE: the flag bank is architecturally visible status, so it is reset
    // like any other register rather than left to power-up values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            err_q     <= 1'b0;
            err_src_q <= '0;
        end else begin
            q_q       <= q_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
        end
    end

    // Registered grant and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign err_src = err_src_q;

endmodule

// File: tb/tb_sr_flag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_ctrl
//
// Directed bench for sr_flag_ctrl. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_sr_flag_ctrl;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_op;
    logic [IDXW*NREQ-1:0]  req_idx;
    logic                  err_clr;
    logic [NREQ-1:0]       gnt;
    logic [NFLAG-1:0]      q;
    logic                  busy;
    logic                  err;
    logic [IDXW-1:0]       err_src;

    int total = 0;
    int bad   = 0;

    sr_flag_ctrl #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_op  (req_op),
        .req_idx (req_idx),
        .err_clr (err_clr),
        .gnt     (gnt),
        .q       (q),
        .busy    (busy),
        .err     (err),
        .err_src (err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full clock: through the rising edge to the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int k, input logic [1:0] op, input logic [IDXW-1:0] idx);
        req[k]                  = 1'b1;
        req_op[2*k +: 2]        = op;
        req_idx[IDXW*k +: IDXW] = idx;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        err_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One complete command with the requester holding req until it sees gnt
    task automatic run_op(input string name, input int k, input logic [1:0] op,
                          input logic [IDXW-1:0] idx, input logic [NFLAG-1:0] exp_q,
                          input logic exp_err, input logic [IDXW-1:0] exp_src);
        logic [NREQ-1:0] exp_g;
        exp_g    = '0;
        exp_g[k] = 1'b1;
        drive(k, op, idx);
        step();   // capture edge
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_apply: got %b want 1", name, busy); end
        total++; if (gnt !== '0) begin bad++; $display("FAIL %s_gnt_early: got %b want 0000", name, gnt); end
        step();   // apply edge
        total++; if (q !== exp_q) begin bad++; $display("FAIL %s_q: got %h want %h", name, q, exp_q); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL %s_err: got %b want %b", name, err, exp_err); end
        total++; if (err_src !== exp_src) begin bad++; $display("FAIL %s_err_src: got %0d want %0d", name, err_src, exp_src); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_ack: got %b want 1", name, busy); end
        step();   // ack edge: grant visible now
        total++; if (gnt !== exp_g) begin bad++; $display("FAIL %s_gnt: got %b want %b", name, gnt, exp_g); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_done: got %b want 0", name, busy); end
        req[k] = 1'b0;
        step();
        total++; if (gnt !== '0) begin bad++; $display("FAIL %s_gnt_pulse: got %b want 0000", name, gnt); end
        total++; if (q !== exp_q) begin bad++; $display("FAIL %s_q_hold: got %h want %h", name, q, exp_q); end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", q); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (err_src !== 3'd0) begin bad++; $display("FAIL reset_err_src: got %0d want 0", err_src); end
    endtask

    task automatic test_set_reset_hold();
        run_op("set",   0, 2'b10, 3'd3, 8'h08, 1'b0, 3'd0);
        run_op("clear", 1, 2'b01, 3'd3, 8'h00, 1'b0, 3'd0);
        run_op("hold",  2, 2'b00, 3'd5, 8'h00, 1'b0, 3'd0);
        run_op("set5",  2, 2'b10, 3'd5, 8'h20, 1'b0, 3'd0);
    endtask

    task automatic test_illegal();
        run_op("illegal", 3, 2'b11, 3'd6, 8'h20, 1'b1, 3'd6);
        // err_clr on its own clears err but leaves err_src alone
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL errclr_err: got %b want 0", err); end
        total++; if (err_src !== 3'd6) begin bad++; $display("FAIL errclr_src: got %0d want 6", err_src); end
        // err_clr coincident with a trapped op: the set wins
        drive(0, 2'b11, 3'd2);
        step();   // capture
        err_clr = 1'b1;
        step();   // apply edge with err_clr high
        err_clr = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL errclr_race_err: got %b want 1", err); end
        total++; if (err_src !== 3'd2) begin bad++; $display("FAIL errclr_race_src: got %0d want 2", err_src); end
        total++; if (q !== 8'h20) begin bad++; $display("FAIL errclr_race_q: got %h want 20", q); end
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL errclr_race_gnt: got %b want 0001", gnt); end
        req = '0;
        step();
    endtask

    task automatic test_fairness();
        int got;
        logic [NREQ-1:0] exp_g;
        logic [NFLAG-1:0] exp_q;
        do_reset();
        for (int k = 0; k < NREQ; k++) drive(k, 2'b10, IDXW'(k));
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            step();
            if (gnt !== '0) begin
                exp_g = '0;
`ifdef SR_FLAG_CTRL_FIXED_PRIO_EN
                exp_g[0] = 1'b1;
`else
                exp_g[got % NREQ] = 1'b1;
`endif
                total++; if (gnt !== exp_g) begin bad++; $display("FAIL fair_gnt%0d: got %b want %b", got, gnt, exp_g); end
                got++;
            end
        end
        total++; if (got != 5) begin bad++; $display("FAIL fair_timeout: got %0d grants want 5", got); end
        req = '0;
        repeat (4) step();
`ifdef SR_FLAG_CTRL_FIXED_PRIO_EN
        exp_q = 8'h01;
`else
        exp_q = 8'h0F;
`endif
        total++; if (q !== exp_q) begin bad++; $display("FAIL fair_q: got %h want %h", q, exp_q); end
    endtask

    task automatic test_reset_mid_op();
        drive(0, 2'b10, 3'd7);
        step();   // captured, FSM now in APPLY
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
        rst_n = 1'b0;
        req   = '0;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL midrst_q_async: got %h want 00", q); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            total++; if (gnt !== '0) begin bad++; $display("FAIL midrst_gnt%0d: got %b want 0000", c, gnt); end
        end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL midrst_q: got %h want 00", q); end
        // Pointer must be back at 0: requester 0 beats requester 1
        drive(0, 2'b00, 3'd0);
        drive(1, 2'b00, 3'd1);
        repeat (3) step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL midrst_ptr: got %b want 0001", gnt); end
        req = '0;
        step();
    endtask

    task automatic test_drop_before_gnt();
        drive(0, 2'b10, 3'd2);
        step();   // captured
        req[0]      = 1'b0;
        req_op[1:0] = 2'b01;
        step();
        total++; if (q !== 8'h04) begin bad++; $display("FAIL drop_q: got %h want 04", q); end
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_gnt: got %b want 0001", gnt); end
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL drop_gnt_end: got %b want 0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %b want 0", busy); end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        req_op  = '0;
        req_idx = '0;
        err_clr = 1'b0;
        test_reset();
        test_set_reset_hold();
        test_illegal();
        test_fairness();
        test_reset_mid_op();
        test_drop_before_gnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
